// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
//   arb_state_e  : arbiter FSM states (IDLE, GNT_I, GNT_D)
//   req_e        : requester identity used for round-robin history
//   RESET_VECTOR : first instruction fetch address after reset
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_e;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant decision
//   req[0] : instruction-port request, req[1] : data-port request
//   last   : requester granted most recently
//   gnt    : one-hot grant (all zero when nobody requests)
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  req_e       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      // On a tie the requester that did not win last time goes first.
      if (req == 2'b11) begin
         gnt = (last == REQ_D) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of instruction and data ports onto one memory port
//   clk, reset_n                      : clock, synchronous active-low reset
//   i_read/i_address/i_readdata/i_waitrequest : instruction (read-only) port
//   d_read/d_write/d_address/d_byteenable/d_writedata/d_readdata/d_waitrequest : data port
//   m_read/m_write/m_address/m_byteenable/m_writedata/m_readdata/m_waitrequest : memory port
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_read,
   input  logic [ADDR_W-1:0]   i_address,
   output logic [DATA_W-1:0]   i_readdata,
   output logic                i_waitrequest,
   input  logic                d_read,
   input  logic                d_write,
   input  logic [ADDR_W-1:0]   d_address,
   input  logic [DATA_W/8-1:0] d_byteenable,
   input  logic [DATA_W-1:0]   d_writedata,
   output logic [DATA_W-1:0]   d_readdata,
   output logic                d_waitrequest,
   output logic                m_read,
   output logic                m_write,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic [DATA_W-1:0]   m_writedata,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_waitrequest
);

   arb_state_e state_q, state_d;
   req_e       last_q, last_d;
   logic       i_req, d_req;
   logic [1:0] gnt;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   rr_arb2 u_rr (
      .req  ({d_req, i_req}),
      .last (last_q),
      .gnt  (gnt)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         last_q  <= REQ_D;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      m_read        = 1'b0;
      m_write       = 1'b0;
      m_address     = '0;
      m_byteenable  = '0;
      m_writedata   = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;

      // While reset is held the outputs stay quiet even if the registered
      // state still shows a grant, so an aborted transfer never completes.
      if (reset_n) begin
         case (state_q)
            IDLE: begin
               if (gnt[0]) begin
                  state_d = GNT_I;
               end else if (gnt[1]) begin
                  state_d = GNT_D;
               end
            end

            GNT_I: begin
               m_read       = i_read;
               m_address    = i_address;
               m_byteenable = '1;
               if (i_read && !m_waitrequest) begin
                  i_waitrequest = 1'b0;
                  i_readdata    = m_readdata;
                  last_d        = REQ_I;
                  // Hand over directly so contention costs no idle cycle.
                  state_d       = d_req ? GNT_D : IDLE;
               end else if (!i_read) begin
                  // Request withdrawn mid-grant: abandon without history update.
                  state_d = IDLE;
               end
            end

            GNT_D: begin
               // Write has priority when a requester raises both strobes.
               m_write      = d_write;
               m_read       = d_read & ~d_write;
               m_address    = d_address;
               m_byteenable = d_byteenable;
               m_writedata  = d_writedata;
               if (d_req && !m_waitrequest) begin
                  d_waitrequest = 1'b0;
                  if (!d_write) begin
                     d_readdata = m_readdata;
                  end
                  last_d  = REQ_D;
                  state_d = i_req ? GNT_I : IDLE;
               end else if (!d_req) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_waitrequest;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [3:0]  d_byteenable;
   logic [31:0] d_writedata;
   logic [31:0] d_readdata;
   logic        d_waitrequest;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_address;
   logic [3:0]  m_byteenable;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        m_waitrequest;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_read        (i_read),
      .i_address     (i_address),
      .i_readdata    (i_readdata),
      .i_waitrequest (i_waitrequest),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_address     (d_address),
      .d_byteenable  (d_byteenable),
      .d_writedata   (d_writedata),
      .d_readdata    (d_readdata),
      .d_waitrequest (d_waitrequest),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_address     (m_address),
      .m_byteenable  (m_byteenable),
      .m_writedata   (m_writedata),
      .m_readdata    (m_readdata),
      .m_waitrequest (m_waitrequest)
   );

   task automatic idle_inputs;
      i_read        = 1'b0;
      i_address     = '0;
      d_read        = 1'b0;
      d_write       = 1'b0;
      d_address     = '0;
      d_byteenable  = '0;
      d_writedata   = '0;
      m_readdata    = '0;
      m_waitrequest = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset_n = 1'b0;
      i_read = 1'b1;
      d_write = 1'b1;
      d_address = 32'h55;
      d_writedata = 32'h66;
      d_byteenable = 4'hF;
      m_readdata = 32'h12345678;
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, m_write, m_address, m_byteenable, m_writedata} !== 70'd0)
         $display("FAIL reset_mem: got %h expected 0", {m_read, m_write, m_address, m_byteenable, m_writedata});
      if ({m_read, m_write, m_address, m_byteenable, m_writedata} !== 70'd0) miscompares++;
      vectors++;
      if ({i_waitrequest, d_waitrequest, i_readdata, d_readdata} !== {2'b11, 64'd0}) begin
         miscompares++;
         $display("FAIL reset_req: got %h expected %h", {i_waitrequest, d_waitrequest, i_readdata, d_readdata}, {2'b11, 64'd0});
      end
      @(negedge clk);
      idle_inputs();
      reset_n = 1'b1;
      #1;
      vectors++;
      if ({m_read, m_write, i_waitrequest, d_waitrequest} !== 4'b0011) begin
         miscompares++;
         $display("FAIL post_reset_idle: got %b expected 0011", {m_read, m_write, i_waitrequest, d_waitrequest});
      end
   endtask

   task automatic test_i_read;
      @(negedge clk);
      i_read = 1'b1;
      i_address = RESET_VECTOR;
      m_readdata = 32'h8C020000;
      m_waitrequest = 1'b0;
      #1;
      vectors++;
      if ({m_read, i_waitrequest} !== 2'b01) begin
         miscompares++;
         $display("FAIL i_read_arb_cycle: got %b expected 01", {m_read, i_waitrequest});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, m_write, m_address, m_byteenable, m_writedata} !== {1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'd0}) begin
         miscompares++;
         $display("FAIL i_read_mem: got %h expected %h", {m_read, m_write, m_address, m_byteenable, m_writedata},
                  {1'b1, 1'b0, 32'hBFC00000, 4'hF, 32'd0});
      end
      vectors++;
      if ({i_waitrequest, i_readdata, d_waitrequest} !== {1'b0, 32'h8C020000, 1'b1}) begin
         miscompares++;
         $display("FAIL i_read_done: got %h expected %h", {i_waitrequest, i_readdata, d_waitrequest}, {1'b0, 32'h8C020000, 1'b1});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, i_waitrequest, i_readdata} !== {2'b01, 32'd0}) begin
         miscompares++;
         $display("FAIL i_read_gap: got %h expected %h", {m_read, i_waitrequest, i_readdata}, {2'b01, 32'd0});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, i_waitrequest} !== 2'b10) begin
         miscompares++;
         $display("FAIL i_read_second: got %b expected 10", {m_read, i_waitrequest});
      end
      @(negedge clk);
      i_read = 1'b0;
   endtask

   task automatic test_tie;
      do_reset();
      i_read = 1'b1;
      i_address = 32'h1000;
      d_read = 1'b1;
      d_address = 32'h2000;
      m_readdata = 32'h11111111;
      m_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, m_address, i_waitrequest, d_waitrequest, i_readdata} !== {1'b1, 32'h1000, 2'b01, 32'h11111111}) begin
         miscompares++;
         $display("FAIL tie_first_i: got %h expected %h", {m_read, m_address, i_waitrequest, d_waitrequest, i_readdata},
                  {1'b1, 32'h1000, 2'b01, 32'h11111111});
      end
      @(negedge clk);
      i_read = 1'b0;
      #1;
      vectors++;
      if ({m_read, m_address, i_waitrequest, d_waitrequest, d_readdata, i_readdata} !== {1'b1, 32'h2000, 2'b10, 32'h11111111, 32'd0}) begin
         miscompares++;
         $display("FAIL tie_then_d: got %h expected %h", {m_read, m_address, i_waitrequest, d_waitrequest, d_readdata, i_readdata},
                  {1'b1, 32'h2000, 2'b10, 32'h11111111, 32'd0});
      end
      @(negedge clk);
      d_read = 1'b0;
   endtask

   task automatic test_contention;
      logic [31:0] exp_data;
      bit          exp_i;
      int          i_cnt;
      int          d_cnt;
      i_cnt = 0;
      d_cnt = 0;
      @(negedge clk);
      i_read = 1'b1;
      i_address = 32'h3000;
      d_read = 1'b1;
      d_address = 32'h4000;
      m_waitrequest = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_data = 32'hA0000000 | 32'(k);
         m_readdata = exp_data;
         exp_i = (k % 2 == 0);
         #1;
         vectors++;
         if ({i_waitrequest, d_waitrequest} !== (exp_i ? 2'b01 : 2'b10)) begin
            miscompares++;
            $display("FAIL contention_grant_%0d: got %b expected %b", k, {i_waitrequest, d_waitrequest}, exp_i ? 2'b01 : 2'b10);
         end
         vectors++;
         if ({i_readdata, d_readdata} !== (exp_i ? {exp_data, 32'd0} : {32'd0, exp_data})) begin
            miscompares++;
            $display("FAIL contention_data_%0d: got %h expected %h", k, {i_readdata, d_readdata},
                     exp_i ? {exp_data, 32'd0} : {32'd0, exp_data});
         end
         if (!i_waitrequest) i_cnt++;
         if (!d_waitrequest) d_cnt++;
      end
      vectors++;
      if (i_cnt != 4 || d_cnt != 4) begin
         miscompares++;
         $display("FAIL contention_counts: got i=%0d d=%0d expected i=4 d=4", i_cnt, d_cnt);
      end
      // Withdraw while the instruction port holds a stalled grant.
      @(negedge clk);
      i_read = 1'b0;
      d_read = 1'b0;
      m_waitrequest = 1'b1;
      #1;
      vectors++;
      if ({m_read, i_waitrequest, d_waitrequest} !== 3'b011) begin
         miscompares++;
         $display("FAIL drop_grant: got %b expected 011", {m_read, i_waitrequest, d_waitrequest});
      end
      // Back in IDLE with history still D, a fresh tie must go to I.
      @(negedge clk);
      i_read = 1'b1;
      d_read = 1'b1;
      m_waitrequest = 1'b0;
      m_readdata = 32'h5;
      @(negedge clk);
      #1;
      vectors++;
      if ({m_address, i_waitrequest, d_waitrequest} !== {32'h3000, 2'b01}) begin
         miscompares++;
         $display("FAIL drop_keeps_last: got %h expected %h", {m_address, i_waitrequest, d_waitrequest}, {32'h3000, 2'b01});
      end
      @(negedge clk);
      i_read = 1'b0;
      @(negedge clk);
      d_read = 1'b0;
   endtask

   task automatic test_wait_states;
      @(negedge clk);
      d_write = 1'b1;
      d_address = 32'h100;
      d_writedata = 32'hF;
      d_byteenable = 4'h3;
      m_readdata = 32'hFFFFFFFF;
      m_waitrequest = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         m_waitrequest = (k < 4);
         #1;
         vectors++;
         if ({m_read, m_write, m_address, m_writedata, m_byteenable} !== {2'b01, 32'h100, 32'hF, 4'h3}) begin
            miscompares++;
            $display("FAIL wait_mem_%0d: got %h expected %h", k, {m_read, m_write, m_address, m_writedata, m_byteenable},
                     {2'b01, 32'h100, 32'hF, 4'h3});
         end
         vectors++;
         if ({d_waitrequest, d_readdata} !== {(k != 4), 32'd0}) begin
            miscompares++;
            $display("FAIL wait_resp_%0d: got %h expected %h", k, {d_waitrequest, d_readdata}, {(k != 4), 32'd0});
         end
      end
      @(negedge clk);
      d_write = 1'b0;
      m_waitrequest = 1'b0;
      #1;
      vectors++;
      if ({m_write, m_address} !== 33'd0) begin
         miscompares++;
         $display("FAIL wait_idle_after: got %h expected 0", {m_write, m_address});
      end
   endtask

   task automatic test_conflict;
      @(negedge clk);
      d_read = 1'b1;
      d_write = 1'b1;
      d_address = 32'h200;
      d_writedata = 32'h1234;
      d_byteenable = 4'hF;
      m_readdata = 32'hDEAD;
      m_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if ({m_write, m_read, m_writedata, d_waitrequest, d_readdata} !== {2'b10, 32'h1234, 1'b0, 32'd0}) begin
         miscompares++;
         $display("FAIL conflict: got %h expected %h", {m_write, m_read, m_writedata, d_waitrequest, d_readdata},
                  {2'b10, 32'h1234, 1'b0, 32'd0});
      end
      @(negedge clk);
      d_read = 1'b0;
      d_write = 1'b0;
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      i_read = 1'b1;
      i_address = 32'h400;
      m_readdata = 32'h77;
      m_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      vectors++;
      if (i_waitrequest !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_pre_i: got %b expected 0", i_waitrequest);
      end
      @(negedge clk);
      i_read = 1'b0;
      d_write = 1'b1;
      d_address = 32'h300;
      d_writedata = 32'h5A;
      d_byteenable = 4'hF;
      m_waitrequest = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if ({m_write, m_address, d_waitrequest} !== {1'b1, 32'h300, 1'b1}) begin
         miscompares++;
         $display("FAIL mid_gnt_d: got %h expected %h", {m_write, m_address, d_waitrequest}, {1'b1, 32'h300, 1'b1});
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({m_read, m_write, m_address, d_waitrequest, i_waitrequest} !== {2'b00, 32'd0, 2'b11}) begin
         miscompares++;
         $display("FAIL mid_in_reset: got %h expected %h", {m_read, m_write, m_address, d_waitrequest, i_waitrequest},
                  {2'b00, 32'd0, 2'b11});
      end
      @(negedge clk);
      reset_n = 1'b1;
      i_read = 1'b1;
      m_waitrequest = 1'b0;
      #1;
      vectors++;
      if ({m_read, m_write, d_waitrequest, i_waitrequest} !== 4'b0011) begin
         miscompares++;
         $display("FAIL mid_after_reset: got %b expected 0011", {m_read, m_write, d_waitrequest, i_waitrequest});
      end
      @(negedge clk);
      #1;
      vectors++;
      if ({m_read, m_address, i_waitrequest, d_waitrequest} !== {1'b1, 32'h400, 2'b01}) begin
         miscompares++;
         $display("FAIL mid_tie_to_i: got %h expected %h", {m_read, m_address, i_waitrequest, d_waitrequest}, {1'b1, 32'h400, 2'b01});
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_i_read();
      test_tie();
      test_contention();
      test_wait_states();
      test_conflict();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
